// File: rtl/psk_pkg.sv
// Shared types and constants for the PSK modulator: FSM state encoding and payload byte width.
package psk_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    PSK_IDLE  = 1'b0,
    PSK_SHIFT = 1'b1
  } psk_state_e;

endpackage

// File: rtl/psk_modulator_if.sv
// Byte handshake between a payload source (master) and the PSK modulator (slave).
interface psk_modulator_if;
  import psk_pkg::*;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_data, output byte_valid, input  byte_ready);
  modport slave  (input  byte_data, input  byte_valid, output byte_ready);

endinterface

// File: rtl/psk_negate_sat.sv
// Per-channel polarity mux: passes the sample or returns its saturating two's-complement negation.
module psk_negate_sat #(
  parameter int DATA_W = 12
) (
  input  logic [DATA_W-1:0] din,
  input  logic              pass,
  output logic [DATA_W-1:0] dout
);

  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};

  always_comb begin
    if (pass) begin
      dout = din;
    end else if (din == MIN_V) begin
      // The most-negative value has no positive counterpart, so clamp it.
      dout = MAX_V;
    end else begin
      dout = (~din) + DATA_W'(1);
    end
  end

endmodule

// File: rtl/psk_modulator.sv
// BPSK modulator: shifts bytes out MSB first and flips NUM_CH carriers by the current bit.
// Define PSK_DIFF_ENC_EN to build the differential (DBPSK) variant with a polarity register.
module psk_modulator
  import psk_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] carrier_in,
  input  logic [DIV_W-1:0]         sym_div,
  psk_modulator_if.slave           byte_if,
  output logic [NUM_CH*DATA_W-1:0] mod_out,
  output logic                     mod_active,
  output logic                     sym_tick,
  output logic                     underrun
);

  psk_state_e               state_q, state_d;
  logic [DIV_W-1:0]         sym_cnt_q, sym_cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]        shreg_q, shreg_d;
  logic [NUM_CH*DATA_W-1:0] mod_out_q, mod_out_d;
  logic                     mod_active_q, mod_active_d;
  logic                     sym_tick_q, sym_tick_d;
  logic                     underrun_q, underrun_d;

  logic                     tick, last_bit, byte_ready, do_load, do_shift;
  logic                     polarity;
  logic [NUM_CH*DATA_W-1:0] chan_val;

  // sym_div is compared with >= so a live shrink below sym_cnt still closes the symbol.
  assign tick       = (state_q == PSK_SHIFT) && (sym_cnt_q >= sym_div);
  assign last_bit   = tick && (bit_idx_q == 3'd0);
  assign byte_ready = (state_q == PSK_IDLE) || last_bit;
  assign do_load    = byte_if.byte_valid && byte_ready;
  assign do_shift   = tick && (bit_idx_q != 3'd0);

  assign byte_if.byte_ready = byte_ready;

`ifdef PSK_DIFF_ENC_EN
  logic pol_q, pol_d;

  // Toggle whenever a 1 becomes the current bit; the register survives IDLE.
  always_comb begin
    pol_d = pol_q;
    if (do_load) begin
      if (byte_if.byte_data[BYTE_W-1]) pol_d = ~pol_q;
    end else if (do_shift) begin
      if (shreg_q[BYTE_W-2]) pol_d = ~pol_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pol_q <= 1'b1;
    else          pol_q <= pol_d;
  end

  assign polarity = pol_q;
`else
  assign polarity = shreg_q[BYTE_W-1];
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    psk_negate_sat #(.DATA_W(DATA_W)) u_neg (
      .din  (carrier_in[k*DATA_W +: DATA_W]),
      .pass (polarity),
      .dout (chan_val[k*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;

    if (state_q == PSK_SHIFT) begin
      sym_cnt_d = tick ? '0 : sym_cnt_q + DIV_W'(1);
    end
    if (do_shift) begin
      shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
      bit_idx_d = bit_idx_q - 3'd1;
    end
    if (do_load) begin
      shreg_d   = byte_if.byte_data;
      bit_idx_d = 3'(BYTE_W-1);
      sym_cnt_d = '0;
      state_d   = PSK_SHIFT;
    end else if (last_bit) begin
      state_d   = PSK_IDLE;
    end

    mod_out_d    = (state_q == PSK_SHIFT) ? chan_val : '0;
    mod_active_d = (state_q == PSK_SHIFT);
    sym_tick_d   = tick;
    underrun_d   = last_bit && !do_load;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q      <= PSK_IDLE;
      sym_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      mod_out_q    <= '0;
      mod_active_q <= 1'b0;
      sym_tick_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      mod_out_q    <= mod_out_d;
      mod_active_q <= mod_active_d;
      sym_tick_q   <= sym_tick_d;
      underrun_q   <= underrun_d;
    end
  end

  assign mod_out    = mod_out_q;
  assign mod_active = mod_active_q;
  assign sym_tick   = sym_tick_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_psk_modulator.sv
// Directed self-checking bench for psk_modulator (DATA_W=12, NUM_CH=4).
// Polarity-dependent sequences follow the build: raw BPSK by default, DBPSK with PSK_DIFF_ENC_EN.
module tb_psk_modulator;

  localparam int DATA_W = 12;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int W      = NUM_CH * DATA_W;

  logic             clk;
  logic             reset_n;
  logic [W-1:0]     carrier_in;
  logic [DIV_W-1:0] sym_div;
  logic [W-1:0]     mod_out;
  logic             mod_active;
  logic             sym_tick;
  logic             underrun;

  int checks = 0;
  int errors = 0;

  psk_modulator_if bif ();

  psk_modulator #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .carrier_in (carrier_in),
    .sym_div    (sym_div),
    .byte_if    (bif.slave),
    .mod_out    (mod_out),
    .mod_active (mod_active),
    .sym_tick   (sym_tick),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rep(input int v);
    logic [DATA_W-1:0] s;
    s = v[DATA_W-1:0];
    return {NUM_CH{s}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sgn [8];
    logic seen;

    clk            = 1'b0;
    reset_n        = 1'b0;
    carrier_in     = rep(100);
    sym_div        = 16'd3;
    bif.byte_data  = 8'h00;
    bif.byte_valid = 1'b0;

    // Reset values
    step();
    step();
    check("rst_mod_out",  mod_out,        '0);
    check("rst_active",   mod_active,     1'b0);
    check("rst_sym_tick", sym_tick,       1'b0);
    check("rst_underrun", underrun,       1'b0);
    check("rst_ready",    bif.byte_ready, 1'b1);
    reset_n = 1'b1;

`ifdef PSK_DIFF_ENC_EN
    // DBPSK: 0xC0 -> -,+,+,+,+,+,+,+ at one bit per clock
    sym_div        = 16'd0;
    bif.byte_data  = 8'hC0;
    bif.byte_valid = 1'b1;
    step();
    bif.byte_valid = 1'b0;
    for (int n = 2; n <= 9; n++) begin
      step();
      check("dbpsk_out", mod_out, rep(n == 2 ? -100 : 100));
    end
    step();
    check("dbpsk_idle_out", mod_out, '0);
`else
    // 0xA5 at sym_div=3: first transfer on the first edge after reset release
    bif.byte_data  = 8'hA5;
    bif.byte_valid = 1'b1;
    check("a5_ready", bif.byte_ready, 1'b1);
    step();
    bif.byte_valid = 1'b0;
    check("a5_load_mute", mod_out, '0);
    sgn = '{1, -1, 1, -1, -1, 1, -1, 1};
    for (int n = 2; n <= 33; n++) begin
      step();
      check("a5_out",      mod_out,    rep(100 * sgn[(n-2)/4]));
      check("a5_active",   mod_active, 1'b1);
      check("a5_sym_tick", sym_tick,   (n >= 5) && ((n - 5) % 4 == 0));
      check("a5_underrun", underrun,   n == 33);
    end
    step();
    check("a5_idle_out",      mod_out,    '0);
    check("a5_idle_active",   mod_active, 1'b0);
    check("a5_idle_underrun", underrun,   1'b0);

    // Saturating negate: ch0=-2048, ch1=2047, ch2=0, ch3=100; byte 0x0F, one bit per clock
    carrier_in     = {12'd100, 12'd0, 12'd2047, 12'h800};
    sym_div        = 16'd0;
    bif.byte_data  = 8'h0F;
    bif.byte_valid = 1'b1;
    step();
    bif.byte_valid = 1'b0;
    step();
    check("sat_neg", mod_out, {12'hF9C, 12'h000, 12'h801, 12'h7FF});
    step();
    step();
    step();
    step();
    check("sat_pass", mod_out, {12'd100, 12'd0, 12'd2047, 12'h800});
    carrier_in = rep(5);
    step();
    check("sat_latency", mod_out, rep(5));
    step();
    step();
    check("sat_underrun", underrun, 1'b1);
    step();
    check("sat_idle_out", mod_out, '0);

    // Back-to-back 0xFF then 0x00 with byte_valid held, sym_div=0
    carrier_in     = rep(100);
    bif.byte_data  = 8'hFF;
    bif.byte_valid = 1'b1;
    step();
    bif.byte_data  = 8'h00;
    for (int n = 2; n <= 17; n++) begin
      step();
      check("b2b_out",      mod_out,    rep(n <= 9 ? 100 : -100));
      check("b2b_active",   mod_active, 1'b1);
      check("b2b_underrun", underrun,   n == 17);
      if (n == 8) check("b2b_ready_last", bif.byte_ready, 1'b1);
      if (n == 9) begin
        check("b2b_ready_after", bif.byte_ready, 1'b0);
        bif.byte_valid = 1'b0;
      end
    end
    step();
    check("b2b_idle_out", mod_out, '0);
`endif

    // Reset during bit 3 of 0xF0 (sym_div=1): everything mutes at once, nothing resumes
    carrier_in     = rep(100);
    sym_div        = 16'd1;
    bif.byte_data  = 8'hF0;
    bif.byte_valid = 1'b1;
    step();
    bif.byte_valid = 1'b0;
    for (int n = 2; n <= 9; n++) step();
    check("rstmid_active_before", mod_active, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rstmid_out",      mod_out,        '0);
    check("rstmid_active",   mod_active,     1'b0);
    check("rstmid_sym_tick", sym_tick,       1'b0);
    check("rstmid_underrun", underrun,       1'b0);
    check("rstmid_ready",    bif.byte_ready, 1'b1);
    step();
    step();
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      check("rstpost_out",      mod_out,        '0);
      check("rstpost_active",   mod_active,     1'b0);
      check("rstpost_underrun", underrun,       1'b0);
      check("rstpost_ready",    bif.byte_ready, 1'b1);
    end

    // sym_div cut from 9 to 2 while sym_cnt=5: immediate boundary, then 3-cycle symbols
    sym_div        = 16'd9;
    bif.byte_data  = 8'hFF;
    bif.byte_valid = 1'b1;
    step();
    bif.byte_valid = 1'b0;
    for (int n = 2; n <= 6; n++) begin
      step();
      check("div_no_tick", sym_tick, 1'b0);
    end
    sym_div = 16'd2;
    for (int n = 7; n <= 13; n++) begin
      step();
      check("div_sym_tick", sym_tick, (n == 7) || (n == 10) || (n == 13));
    end
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (underrun) begin
        seen = 1'b1;
        break;
      end
    end
    check("div_underrun_seen", seen, 1'b1);
    step();
    check("div_idle_out", mod_out, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psk_modulator.md
PSK_MODULATOR -- requirements
Module: psk_modulator

Interface
REQ-001 Parameter DATA_W, default 12: signed two's-complement sample width per channel.
REQ-002 Parameter NUM_CH, default 4: number of carrier channels modulated by the common bit stream.
REQ-003 Parameter DIV_W, default 16: width of the symbol-period divisor.
REQ-004 Port clk, in, 1: single clock; the block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port reset_n, in, 1: asynchronous active-low reset.
REQ-006 Port carrier_in, in, NUM_CH*DATA_W: carrier samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 Port sym_div, in, DIV_W: clocks per symbol minus 1.
REQ-008 Port byte_data, in, 8: payload byte, transmitted MSB first.
REQ-009 Port byte_valid, in, 1: byte_data is valid.
REQ-010 Port byte_ready, out, 1: the block accepts byte_data this cycle.
REQ-011 Port mod_out, out, NUM_CH*DATA_W: registered modulated samples, same channel packing as carrier_in.
REQ-012 Port mod_active, out, 1: registered; high while a symbol is being transmitted.
REQ-013 Port sym_tick, out, 1: one-cycle pulse on every symbol boundary.
REQ-014 Port underrun, out, 1: one-cycle pulse when a byte completes with no successor available.

Function
REQ-015 The FSM SHALL have two states. IDLE: byte_ready=1. SHIFT: the byte is being transmitted.
REQ-016 A transfer SHALL occur only when byte_valid and byte_ready are both 1 in the same cycle.
REQ-017 On a transfer from IDLE, the FSM SHALL load the shift register, set bit_idx=7, clear sym_cnt to 0 and enter SHIFT.
REQ-018 In SHIFT, sym_cnt SHALL increment every cycle; tick SHALL be true when sym_cnt >= sym_div. A live change to sym_div therefore never skips a boundary.
REQ-019 On tick, sym_cnt SHALL return to 0 and sym_tick SHALL pulse in the following cycle, aligned with the first output of the new symbol.
REQ-020 On tick with bit_idx>0, the shift register SHALL shift left and bit_idx SHALL decrement.
REQ-021 On tick with bit_idx=0, byte_ready SHALL be 1 (combinational).
  - If byte_valid=1, the new byte SHALL load with bit_idx=7 and SHIFT continues with no gap.
  - Otherwise the FSM SHALL enter IDLE and underrun SHALL pulse in the next cycle.
REQ-022 With sym_div=0, every SHIFT cycle SHALL be a tick, i.e. one bit per clock.
REQ-023 The current bit SHALL be shift register bit 7. Polarity: bit=1 gives +carrier, bit=0 gives -carrier.
REQ-024 Negation SHALL be saturating. The most-negative value (-2048 at DATA_W=12) maps to +2047. All other values map to the exact two's complement negation.
REQ-025 mod_out SHALL be registered, with one cycle of latency from carrier_in to mod_out. Polarity SHALL be taken from the bit current in the same cycle carrier_in is sampled.
REQ-026 In IDLE, mod_out SHALL be all zeros (carrier muted) and mod_active SHALL be 0.
REQ-027 All NUM_CH channels SHALL share one polarity per cycle.

Reset
REQ-028 While reset_n=0, the block SHALL hold these values: state IDLE, sym_cnt 0, bit_idx 0, shift register 0, mod_out 0, mod_active 0, sym_tick 0, underrun 0. Any in-flight byte SHALL be discarded.
REQ-029 After reset_n deasserts, the first transfer SHALL be possible in the first clock edge.

Configuration
REQ-030 Macro PSK_DIFF_ENC_EN SHALL select differential (DBPSK) encoding.
  - Defined: a polarity register, reset to 1, SHALL toggle whenever a new bit equal to 1 becomes current (on load or shift). The polarity register replaces the raw bit in REQ-023. The polarity register SHALL persist across IDLE.
  - Undefined: polarity SHALL equal the raw bit, and no polarity register SHALL exist.

Structure
REQ-031 Package psk_pkg SHALL hold the state enum (PSK_IDLE, PSK_SHIFT) and the constant BYTE_W=8.
REQ-032 Sub-module psk_negate_sat SHALL implement a DATA_W-parameterised saturating negate/pass mux, instantiated NUM_CH times.

Verification
REQ-033 Bench configuration DATA_W=12, NUM_CH=4 and PSK_DIFF_ENC_EN undefined unless stated.
  - sym_div=3, byte 0xA5, all carriers constant 100 -> mod_out per symbol: +100,-100,+100,-100,-100,+100,-100,+100. Each symbol lasts 4 cycles; sym_tick occurs every 4 cycles; underrun pulses after the last symbol; mod_out is then 0.
  - Carrier -2048 with bit 0 -> mod_out 2047. Carrier 2047 with bit 0 -> -2047. Carrier 0 -> 0.
  - Back-to-back bytes 0xFF then 0x00 with byte_valid held, sym_div=0 -> 16 consecutive active cycles, 8 at + then 8 at -, with no underrun.
  - reset_n pulsed low during bit 3 of 0xF0 -> all outputs 0 immediately; byte_ready=1 after release; no residual bits are emitted.
  - PSK_DIFF_ENC_EN defined, byte 0xC0 -> polarity sequence -,+,+,+,+,+,+,+ relative to carrier.
  - sym_div changed from 9 to 2 when sym_cnt=5 -> tick on the next cycle; the following symbols are 3 cycles long.
